shift_divider: RTL



---
 rtl/arith_pkg.sv | 12 +
 rtl/div_step.sv | 25 ++
 rtl/shift_divider.sv | 122 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic units (shift-add multiplier, restoring divider).
package arith_pkg;

   localparam int unsigned ARITH_SIZE = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, try to subtract the divisor.
module div_step
   import arith_pkg::*;
#(
   parameter int unsigned size = ARITH_SIZE
) (
   input  logic [size-1:0] r_i,
   input  logic            bit_i,
   input  logic [size-1:0] d_i,
   output logic [size-1:0] r_o,
   output logic            q_o
);

   logic [size:0] shifted;
   logic [size:0] trial;

   // A set top bit in the (size+1)-bit difference means the trial went negative.
   always_comb begin
      shifted = {r_i, bit_i};
      trial   = shifted - {1'b0, d_i};
      q_o     = ~trial[size];
      r_o     = q_o ? trial[size-1:0] : shifted[size-1:0];
   end

endmodule

// File: rtl/shift_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with busy/done handshake.
module shift_divider
   import arith_pkg::*;
#(
   parameter int unsigned size = ARITH_SIZE
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [size-1:0] dividend,
   input  logic [size-1:0] divisor,
   output logic [size-1:0] quotient,
   output logic [size-1:0] remainder,
   output logic            busy,
   output logic            done,
   output logic            div_by_zero
);

   localparam int unsigned CW = (size > 2) ? $clog2(size) : 1;

   div_state_e      state_q, state_d;
   logic [size-1:0] q_q, q_d;
   logic [size-1:0] d_q, d_d;
   // Partial remainder stays below D, so its extra top bit is always zero and is not stored.
   logic [size-1:0] r_q, r_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [size-1:0] quot_q, quot_d;
   logic [size-1:0] rem_q, rem_d;
   logic            dbz_q, dbz_d;

   logic [size-1:0] r_next;
   logic            q_bit;
   logic [size-1:0] q_shift;

   div_step #(
      .size (size)
   ) u_step (
      .r_i   (r_q),
      .bit_i (q_q[size-1]),
      .d_i   (d_q),
      .r_o   (r_next),
      .q_o   (q_bit)
   );

   assign q_shift = {q_q[size-2:0], q_bit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         d_q     <= d_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      d_d     = d_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               q_d   = dividend;
               r_d   = '0;
               cnt_d = '0;
               if (divisor != '0) begin
                  state_d = RUN;
                  d_d     = divisor;
                  quot_d  = '0;
                  rem_d   = '0;
                  dbz_d   = 1'b0;
               end else begin
                  state_d = DONE;
                  d_d     = '0;
                  quot_d  = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            r_d   = r_next;
            q_d   = q_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(size - 1)) begin
               state_d = DONE;
               quot_d  = q_shift;
               rem_d   = r_next;
               dbz_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule
